// File: rtl/spi_reg_pkg.sv
// ---------------------------------------------------------------------------
// spi_reg_pkg : shared constants and FSM state type for the SPI register block
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spi_reg_pkg;

  localparam int ADDR_WIDTH_DEF     = 7;
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int NUM_CONFIG_REG_DEF = 8;
  localparam int NUM_STATUS_REG_DEF = 4;
  localparam int STATUS_BASE        = 8;
  localparam int FRAME_LEN          = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge : 2-flop synchroniser with rise/fall strobes in the clk domain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // [0] metastable stage, [1] synchronised level, [2] previous level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign dout = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

`default_nettype wire

// File: rtl/spi_reg_responder.sv
// ---------------------------------------------------------------------------
// spi_reg_responder : SPI mode-0 slave exposing config (R/W) and status (RO) regs
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_reg_responder
  import spi_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int NUM_CONFIG_REG = NUM_CONFIG_REG_DEF,
  parameter int NUM_STATUS_REG = NUM_STATUS_REG_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 sck_i,
  input  logic                                 sdi_i,
  input  logic                                 cs_ni,
  output logic                                 sdo_o,
  output logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] config_o,
  input  logic [NUM_STATUS_REG*DATA_WIDTH-1:0] status_i,
  output logic                                 wr_stb_o,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o
);

  localparam int CMD_BITS   = ADDR_WIDTH + 1;
  localparam int FRAME_BITS = CMD_BITS + DATA_WIDTH;
  localparam int SHIFT_W    = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic sdi_sync, sdi_rise, sdi_fall;

  sync_edge u_sync_sck (.clk(clk), .rst_n(rst_n), .din(sck_i),
                        .dout(sck_sync), .rise(sck_rise), .fall(sck_fall));
  sync_edge u_sync_cs  (.clk(clk), .rst_n(rst_n), .din(cs_ni),
                        .dout(cs_sync), .rise(cs_rise), .fall(cs_fall));
  sync_edge u_sync_sdi (.clk(clk), .rst_n(rst_n), .din(sdi_i),
                        .dout(sdi_sync), .rise(sdi_rise), .fall(sdi_fall));

  logic unused_sync;
  assign unused_sync = &{1'b0, sck_sync, cs_sync, sdi_rise, sdi_fall};

  spi_state_e                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic                      is_read_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     rd_shift_q;
  logic                      sdo_q;
  logic                      wr_stb_q;
  logic [ADDR_WIDTH-1:0]     wr_addr_q;
  logic [DATA_WIDTH-1:0]     cfg_q [NUM_CONFIG_REG];

  logic                      cmd_done, frame_done, shift_en, wr_commit;
  logic [CMD_BITS-1:0]       cmd_word;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH-1:0]     rd_data;
  int                        cmd_addr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_done   = 1'b0;
    frame_done = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (sck_rise && bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
            state_d  = ST_DATA;
            cmd_done = 1'b1;
          end
        end
        ST_DATA: begin
          if (sck_rise && bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            state_d    = ST_DONE;
            frame_done = 1'b1;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign shift_en  = sck_rise && !cs_rise && (state_q == ST_CMD || state_q == ST_DATA);
  assign cmd_word  = {shift_q[ADDR_WIDTH-1:0], sdi_sync};
  assign wr_data   = {shift_q[DATA_WIDTH-2:0], sdi_sync};
  assign wr_commit = frame_done && !is_read_q && (32'(addr_q) < NUM_CONFIG_REG);

  // Read mux sees cfg_q before any same-cycle write lands, giving pre-write data
  always_comb begin
    cmd_addr_i = 32'(cmd_word[ADDR_WIDTH-1:0]);
    rd_data    = '0;
    for (int i = 0; i < NUM_CONFIG_REG; i++) begin
      if (cmd_addr_i == i) rd_data = cfg_q[i];
    end
    for (int j = 0; j < NUM_STATUS_REG; j++) begin
      if (cmd_addr_i == STATUS_BASE + j) rd_data = status_i[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      is_read_q  <= 1'b0;
      addr_q     <= '0;
      rd_shift_q <= '0;
      sdo_q      <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      wr_stb_q <= 1'b0;

      if (state_q == ST_IDLE && cs_fall) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        shift_q   <= {shift_q[SHIFT_W-2:0], sdi_sync};
      end

      if (cmd_done) begin
        is_read_q  <= cmd_word[ADDR_WIDTH];
        addr_q     <= cmd_word[ADDR_WIDTH-1:0];
        rd_shift_q <= cmd_word[ADDR_WIDTH] ? rd_data : '0;
      end

      // First falling edge in DATA is sck fall 8, which presents the read MSB
      if (state_q == ST_DATA && is_read_q && !cs_rise) begin
        if (sck_fall) begin
          {sdo_q, rd_shift_q} <= {rd_shift_q, 1'b0};
        end
      end else begin
        sdo_q <= 1'b0;
      end

      if (wr_commit) begin
        wr_stb_q  <= 1'b1;
        wr_addr_q <= addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONFIG_REG; i++) cfg_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CONFIG_REG; i++) begin
        if (wr_commit && 32'(addr_q) == i) cfg_q[i] <= wr_data;
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_CONFIG_REG; g++) begin : g_cfg
      assign config_o[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
    end
  endgenerate

  assign sdo_o     = sdo_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_responder : directed + randomised SPI frames against a register model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_responder;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam int HALF = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sck = 1'b0;
  logic             sdi = 1'b0;
  logic             cs_n = 1'b1;
  logic             sdo;
  logic [NC*DW-1:0] config_o;
  logic [NS*DW-1:0] status;
  logic             wr_stb;
  logic [AW-1:0]    wr_addr;

  always #5 clk = ~clk;

  spi_reg_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONFIG_REG(NC), .NUM_STATUS_REG(NS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sck_i(sck), .sdi_i(sdi), .cs_ni(cs_n),
    .sdo_o(sdo), .config_o(config_o), .status_i(status),
    .wr_stb_o(wr_stb), .wr_addr_o(wr_addr)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [7:0]    cfg_m  [NC];
  logic [7:0]    stat_m [NS];
  int            stb_count = 0;
  logic [AW-1:0] stb_addr = '0;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_count++;
      stb_addr = wr_addr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input int a);
    if (a < NC) return cfg_m[a];
    if (a >= 8 && a < 8 + NS) return stat_m[a-8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_cfg();
    logic [63:0] v = '0;
    for (int i = 0; i < NC; i++) v[i*8 +: 8] = cfg_m[i];
    return v;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_status();
    for (int i = 0; i < NS; i++) status[i*8 +: 8] = stat_m[i];
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sdi = b;
    wait_clks(HALF);
    seen = sdo;
    sck = 1'b1;
    wait_clks(HALF);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    logic b;
    rx = '0;
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < nbits; i++) begin
      send_bit(tx[15-i], b);
      rx = {rx[14:0], b};
    end
    wait_clks(HALF);
    cs_n = 1'b1;
    sdi = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic do_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                          input string tag);
    logic [15:0] rx, exp_rx;
    int s0;
    s0 = stb_count;
    exp_rx = rw ? {8'h00, model_read(int'(addr))} : 16'h0000;
    spi_xfer({rw, addr, data}, 16, rx);
    check({tag, "_sdo"}, 64'(rx), 64'(exp_rx));
    if (!rw && addr < 7'(NC)) begin
      cfg_m[addr[2:0]] = data;
      check({tag, "_stb"}, 64'(stb_count - s0), 64'd1);
      check({tag, "_waddr"}, 64'(stb_addr), 64'(addr));
    end else begin
      check({tag, "_nostb"}, 64'(stb_count - s0), 64'd0);
    end
    check({tag, "_cfg"}, config_o, model_cfg());
    check({tag, "_sdo_idle"}, 64'(sdo), 64'd0);
  endtask

  task automatic do_abort(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                          input int nbits, input string tag);
    logic [15:0] rx;
    int s0;
    s0 = stb_count;
    spi_xfer({rw, addr, data}, nbits, rx);
    check({tag, "_nostb"}, 64'(stb_count - s0), 64'd0);
    check({tag, "_cfg"}, config_o, model_cfg());
    check({tag, "_sdo_idle"}, 64'(sdo), 64'd0);
  endtask

  initial begin
    logic b;
    int s0;
    for (int i = 0; i < NC; i++) cfg_m[i] = 8'h00;
    for (int i = 0; i < NS; i++) stat_m[i] = 8'h00;
    stat_m[1] = 8'hA5;
    apply_status();

    wait_clks(5);
    check("rst_sdo", 64'(sdo), 64'd0);
    check("rst_cfg", config_o, 64'd0);
    check("rst_stb", 64'(wr_stb), 64'd0);
    check("rst_waddr", 64'(wr_addr), 64'd0);
    rst_n = 1'b1;
    wait_clks(5);

    do_frame(1'b1, 7'h00, 8'h00, "rd0_after_rst");
    do_frame(1'b0, 7'h07, 8'hFF, "wr7");
    check("cfg7_byte", 64'(config_o[63:56]), 64'hFF);
    do_frame(1'b1, 7'h07, 8'h00, "rd7");
    do_frame(1'b1, 7'h09, 8'h00, "rd_status1");
    do_frame(1'b1, 7'h20, 8'h00, "rd_unmapped");
    do_frame(1'b0, 7'h08, 8'h5A, "wr_status_addr");
    do_frame(1'b1, 7'h09, 8'h00, "rd_status1_again");

    do_abort(1'b0, 7'h03, 8'h3C, 10, "abort_wr3");
    do_frame(1'b1, 7'h03, 8'h00, "rd3_after_abort");
    do_frame(1'b0, 7'h03, 8'h3C, "wr3");
    do_frame(1'b1, 7'h03, 8'h00, "rd3");

    // Reset in the middle of a write frame with cs held low across release
    do_frame(1'b0, 7'h00, 8'h03, "wr0");
    s0 = stb_count;
    cs_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < 6; i++) send_bit(1'b0, b);
    rst_n = 1'b0;
    for (int i = 0; i < NC; i++) cfg_m[i] = 8'h00;
    wait_clks(3);
    check("midrst_sdo", 64'(sdo), 64'd0);
    check("midrst_cfg", config_o, 64'd0);
    check("midrst_waddr", 64'(wr_addr), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) send_bit(1'b1, b);
    wait_clks(HALF);
    cs_n = 1'b1;
    wait_clks(HALF);
    check("midrst_nostb", 64'(stb_count - s0), 64'd0);
    check("midrst_cfg_after", config_o, 64'd0);
    do_frame(1'b1, 7'h00, 8'h00, "rd0_after_midrst");
    do_frame(1'b0, 7'h05, 8'h81, "wr5_after_midrst");
    do_frame(1'b1, 7'h05, 8'h00, "rd5_after_midrst");

    for (int n = 0; n < 40; n++) begin
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NS; i++) stat_m[i] = 8'($urandom);
        apply_status();
      end
      rw   = 1'($urandom);
      addr = ($urandom_range(0, 3) == 3) ? 7'($urandom) : 7'($urandom_range(0, 11));
      data = 8'($urandom);
      if ($urandom_range(0, 7) == 0)
        do_abort(rw, addr, data, $urandom_range(1, 15), $sformatf("rnd%0d_abort", n));
      else
        do_frame(rw, addr, data, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
